mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
Parametrised, synthesizable self-checking monitor for the processor's data-memory write port. It holds a programmable table of up to DEPTH expected (address, data) writes and compares each memwrite strobe in order. It reports pass, fail or timeout with diagnostic index and code. It sits beside the top-level core in simulation and FPGA bring-up and replaces the hard-coded single-write check in the current benches.

Parameters:
AW, 32, data-address width
DW, 32, write-data width
DEPTH, 16, maximum number of expected writes (power of two, >=2)
TIMEOUT, 4096, cycles in RUN before declaring timeout (0 disables)
STRICT, 1, 1: any write after PASS flags EXTRA failure; 0: writes after PASS are ignored

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  write one table entry (accepted only when not busy)
cfg_idx  in  $clog2(DEPTH)  table entry index
cfg_addr  in  AW  expected address for the entry
cfg_data  in  DW  expected data for the entry
cfg_count  in  $clog2(DEPTH)+1  number of valid entries, latched on start
start  in  1  begin checking (pulse)
memwrite  in  1  monitored write strobe
dataadr  in  AW  monitored write address
writedata  in  DW  monitored write data
busy  out  1  high in RUN
done  out  1  high in PASS/FAIL/TIMEOUT
pass  out  1  high in PASS only
fail_code  out  3  status_e cause (NONE/ADDR/DATA/BOTH/EXTRA/TIMEOUT)
fail_idx  out  $clog2(DEPTH)  entry index at the failure
write_count  out  $clog2(DEPTH)+1  matched writes so far
cycle_count  out  32  cycles spent in RUN, saturating

Behaviour:
- Reset (reset=0, async): state IDLE; busy=done=pass=0; fail_code=NONE; fail_idx=0; write_count=0; cycle_count=0. Table contents are not reset.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered and reflect the state after each edge.
- cfg_we: writes the table entry when state!=RUN. Ignored in RUN. A cfg_idx >= DEPTH cannot occur because the port is exactly sized.
- start in IDLE/PASS/FAIL/TIMEOUT: latch cfg_count (clamped to DEPTH), clear pointer, write_count, cycle_count and fail fields. Next state is RUN, or PASS directly if cfg_count==0. start in RUN is ignored.
- RUN, each edge: cycle_count++ (saturating). If memwrite=1, compare dataadr/writedata with table[ptr].
  - Both equal: ptr++, write_count++. If ptr==count-1, go to PASS on the same edge.
  - Mismatch: go to FAIL with fail_idx=ptr, fail_code ADDR, DATA or BOTH.
  - Comparison uses 4-state case-equality in simulation; X/Z on the monitored bus is a mismatch.
- Timeout: if TIMEOUT!=0 and cycle_count reaches TIMEOUT-1 with no terminal event on that edge, go to TIMEOUT with fail_code=TIMEOUT and fail_idx=ptr. A memwrite on the same edge takes priority over timeout.
- PASS: when STRICT=1, memwrite=1 moves to FAIL with fail_code=EXTRA and fail_idx=count (truncated). When STRICT=0 it stays in PASS.
- FAIL/TIMEOUT are sticky until start or reset.
- Latency: a result is visible one cycle after the sampling edge.
- Reset asserted mid-RUN aborts immediately to IDLE with no verdict.

Decomposition:
- Shared package mips_check_pkg holds:
  - state_e {IDLE, RUN, PASS, FAIL, TIMEOUT}
  - status_e fail codes {NONE=0, ADDR=1, DATA=2, BOTH=3, EXTRA=4, TIMEOUT=5}
  - expect_entry_t struct {addr, data}
- One sub-module, exp_table_ram: DEPTH x (AW+DW) register file with one synchronous write port and one combinational read port, no reset.
- FSM, counters and compare stay in mem_write_checker.

Test Plan:
- Program entry 0 = (84, 0xFFFF7F02), count=1, start, then memwrite with dataadr=84, writedata=0xFFFF7F02 -> next cycle pass=1, done=1, write_count=1, fail_code=NONE.
- Entries (0x50,7),(0x54,7),(0x58,9), count=3; drive writes 0x50/7, 0x54/7, 0x58/8 -> FAIL, fail_idx=2, fail_code=DATA, write_count=2.
- count=1 expecting (84,-33022); drive address 80 with the correct data -> FAIL, fail_code=ADDR, fail_idx=0; subsequent start with correct stimulus -> PASS, proving the verdict clears.
- TIMEOUT=100, count=2, drive no memwrite -> done=1 exactly 100 cycles after start, fail_code=TIMEOUT, fail_idx=0, cycle_count=100.
- STRICT=1: pass a 1-entry run, then one more memwrite -> FAIL, fail_code=EXTRA, fail_idx=1. Repeat with STRICT=0 -> stays PASS.
- Assert reset low mid-RUN, asynchronously between edges -> outputs go to reset values immediately. cfg_we during RUN does not alter the table (verified by a later run passing on the original values). count=0 start -> PASS one cycle later.

Source files
------------

// File: rtl/mem_write_checker_pkg.sv
// Shared FSM states, verdict codes and entry layout for the data-memory write checker.
package mips_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_ADDR    = 3'd1,
        FC_DATA    = 3'd2,
        FC_BOTH    = 3'd3,
        FC_EXTRA   = 3'd4,
        FC_TIMEOUT = 3'd5
    } status_e;

    localparam int ENTRY_AW = 32;
    localparam int ENTRY_DW = 32;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [ENTRY_DW-1:0] data;
    } expect_entry_t;

    function automatic status_e mismatch_code(input logic addr_ok, input logic data_ok);
        status_e code;
        case ({addr_ok, data_ok})
            2'b01:   code = FC_ADDR;
            2'b10:   code = FC_DATA;
            2'b00:   code = FC_BOTH;
            default: code = FC_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Configuration, monitored write port and verdict bundle of the write checker.
interface mem_write_checker_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 16
);
    localparam int IW = $clog2(DEPTH);

    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [IW:0]   cfg_count;
    logic          start;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [2:0]    fail_code;
    logic [IW-1:0] fail_idx;
    logic [IW:0]   write_count;
    logic [31:0]   cycle_count;

    modport master (
        output cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, start,
        output memwrite, dataadr, writedata,
        input  busy, done, pass, fail_code, fail_idx, write_count, cycle_count
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_addr, cfg_data, cfg_count, start,
        input  memwrite, dataadr, writedata,
        output busy, done, pass, fail_code, fail_idx, write_count, cycle_count
    );

endinterface

// File: rtl/mem_write_checker_table.sv
// Expected-write table: DEPTH x W register file, one synchronous write, one combinational read.
module exp_table_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Table write; contents survive reset so a bench can reprogram selectively
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_write_checker.sv
// In-order checker of data-memory writes against a programmed table, with pass/fail/timeout verdict.
module mem_write_checker
    import mips_check_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096,
    parameter bit STRICT  = 1'b1
) (
    input logic              clk,
    input logic              reset,
    mem_write_checker_if.slave bus
);

    localparam int            IW       = $clog2(DEPTH);
    localparam int            CW       = IW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = {{IW{1'b0}}, 1'b1};
    localparam logic [31:0]   TMO_LAST = 32'(TIMEOUT - 1);
    localparam bit            TMO_EN   = (TIMEOUT != 0);

    state_e        r_state, w_state_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [IW-1:0] r_ptr, w_ptr_nxt;
    logic [CW-1:0] r_write_count, w_write_count_nxt;
    logic [31:0]   r_cycle_count, w_cycle_count_nxt;
    status_e       r_fail_code, w_fail_code_nxt;
    logic [IW-1:0] r_fail_idx, w_fail_idx_nxt;
    logic          r_busy, r_done, r_pass;

    logic [AW+DW-1:0] w_rd_entry;
    logic [AW-1:0]    w_exp_addr;
    logic [DW-1:0]    w_exp_data;
    logic             w_addr_ok, w_data_ok, w_last, w_tbl_we;
    logic [CW-1:0]    w_cfg_count;

    assign w_tbl_we = bus.cfg_we && (r_state != S_RUN);

    exp_table_ram #(.DEPTH(DEPTH), .W(AW + DW)) u_table (
        .clk     (clk),
        .i_we    (w_tbl_we),
        .i_waddr (bus.cfg_idx),
        .i_wdata ({bus.cfg_addr, bus.cfg_data}),
        .i_raddr (r_ptr),
        .o_rdata (w_rd_entry)
    );

    assign w_exp_addr  = w_rd_entry[AW+DW-1:DW];
    assign w_exp_data  = w_rd_entry[DW-1:0];
    // Case equality so X/Z on the monitored bus counts as a mismatch in simulation
    assign w_addr_ok   = (bus.dataadr === w_exp_addr);
    assign w_data_ok   = (bus.writedata === w_exp_data);
    assign w_last      = (({1'b0, r_ptr} + ONE_C) == r_count);
    assign w_cfg_count = (bus.cfg_count > DEPTH_C) ? DEPTH_C : bus.cfg_count;

    // Next-state, counter and verdict logic
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_ptr_nxt         = r_ptr;
        w_write_count_nxt = r_write_count;
        w_cycle_count_nxt = r_cycle_count;
        w_fail_code_nxt   = r_fail_code;
        w_fail_idx_nxt    = r_fail_idx;
        case (r_state)
            S_RUN: begin
                if (r_cycle_count != 32'hFFFF_FFFF) begin
                    w_cycle_count_nxt = r_cycle_count + 32'd1;
                end else begin
                    w_cycle_count_nxt = r_cycle_count;
                end
                if (bus.memwrite) begin
                    if (w_addr_ok && w_data_ok) begin
                        w_ptr_nxt         = r_ptr + ONE_C[IW-1:0];
                        w_write_count_nxt = r_write_count + ONE_C;
                        if (w_last) begin
                            w_state_nxt = S_PASS;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_state_nxt     = S_FAIL;
                        w_fail_idx_nxt  = r_ptr;
                        w_fail_code_nxt = mismatch_code(w_addr_ok, w_data_ok);
                    end
                end else if (TMO_EN && (r_cycle_count >= TMO_LAST)) begin
                    w_state_nxt     = S_TIMEOUT;
                    w_fail_idx_nxt  = r_ptr;
                    w_fail_code_nxt = FC_TIMEOUT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (bus.start) begin
                    w_count_nxt       = w_cfg_count;
                    w_ptr_nxt         = {IW{1'b0}};
                    w_write_count_nxt = {CW{1'b0}};
                    w_cycle_count_nxt = 32'd0;
                    w_fail_code_nxt   = FC_NONE;
                    w_fail_idx_nxt    = {IW{1'b0}};
                    if (w_cfg_count == {CW{1'b0}}) begin
                        w_state_nxt = S_PASS;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end else if ((r_state == S_PASS) && STRICT && bus.memwrite) begin
                    w_state_nxt     = S_FAIL;
                    w_fail_code_nxt = FC_EXTRA;
                    w_fail_idx_nxt  = r_count[IW-1:0];
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_count       <= {CW{1'b0}};
            r_ptr         <= {IW{1'b0}};
            r_write_count <= {CW{1'b0}};
            r_cycle_count <= 32'd0;
            r_fail_code   <= FC_NONE;
            r_fail_idx    <= {IW{1'b0}};
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_ptr         <= w_ptr_nxt;
            r_write_count <= w_write_count_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_fail_code   <= w_fail_code_nxt;
            r_fail_idx    <= w_fail_idx_nxt;
            r_busy        <= (w_state_nxt == S_RUN);
            r_done        <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) ||
                             (w_state_nxt == S_TIMEOUT);
            r_pass        <= (w_state_nxt == S_PASS);
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.fail_code   = r_fail_code;
    assign bus.fail_idx    = r_fail_idx;
    assign bus.write_count = r_write_count;
    assign bus.cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: dut_a is STRICT, dut_b is lenient; both see identical stimulus with TIMEOUT=100.
module tb_mem_write_checker;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [IW:0]   cfg_count;
    logic          start;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;

    int vectors     = 0;
    int miscompares = 0;

    mem_write_checker_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) ifa ();
    mem_write_checker_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) ifb ();

    assign ifa.cfg_we = cfg_we;       assign ifb.cfg_we = cfg_we;
    assign ifa.cfg_idx = cfg_idx;     assign ifb.cfg_idx = cfg_idx;
    assign ifa.cfg_addr = cfg_addr;   assign ifb.cfg_addr = cfg_addr;
    assign ifa.cfg_data = cfg_data;   assign ifb.cfg_data = cfg_data;
    assign ifa.cfg_count = cfg_count; assign ifb.cfg_count = cfg_count;
    assign ifa.start = start;         assign ifb.start = start;
    assign ifa.memwrite = memwrite;   assign ifb.memwrite = memwrite;
    assign ifa.dataadr = dataadr;     assign ifb.dataadr = dataadr;
    assign ifa.writedata = writedata; assign ifb.writedata = writedata;

    mem_write_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(100), .STRICT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );
    mem_write_checker #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(100), .STRICT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic program_entry(input logic [IW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input logic [IW:0] n);
        cfg_count = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        memwrite = 1'b1; dataadr = a; writedata = d;
        step();
        memwrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cfg_we = 1'b0; cfg_idx = 4'd0; cfg_addr = 32'd0; cfg_data = 32'd0;
        cfg_count = 5'd0; start = 1'b0; memwrite = 1'b0; dataadr = 32'd0; writedata = 32'd0;
        step(); step();
        vectors++;
        if ({ifa.busy, ifa.done, ifa.pass} !== 3'b000) begin
            miscompares++; $display("FAIL reset.flags got %b want 000", {ifa.busy, ifa.done, ifa.pass});
        end
        vectors++;
        if ({ifa.fail_code, ifa.fail_idx, ifa.write_count} !== 12'd0) begin
            miscompares++; $display("FAIL reset.fields got %h want 000", {ifa.fail_code, ifa.fail_idx, ifa.write_count});
        end
        vectors++;
        if (ifa.cycle_count !== 32'd0) begin
            miscompares++; $display("FAIL reset.cycle_count got %0d want 0", ifa.cycle_count);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_pass();
        program_entry(4'd0, 32'd84, 32'hFFFF7F02);
        start_run(5'd1);
        vectors++;
        if (ifa.busy !== 1'b1) begin
            miscompares++; $display("FAIL single.busy got %b want 1", ifa.busy);
        end
        bus_write(32'd84, 32'hFFFF7F02);
        vectors++;
        if ({ifa.busy, ifa.done, ifa.pass} !== 3'b011) begin
            miscompares++; $display("FAIL single.flags got %b want 011", {ifa.busy, ifa.done, ifa.pass});
        end
        vectors++;
        if (ifa.write_count !== 5'd1 || ifa.fail_code !== 3'd0) begin
            miscompares++; $display("FAIL single.wc_fc got %0d/%0d want 1/0", ifa.write_count, ifa.fail_code);
        end
        vectors++;
        if (ifa.cycle_count !== 32'd1) begin
            miscompares++; $display("FAIL single.cycle_count got %0d want 1", ifa.cycle_count);
        end
    endtask

    task automatic test_data_mismatch();
        program_entry(4'd0, 32'h50, 32'd7);
        program_entry(4'd1, 32'h54, 32'd7);
        program_entry(4'd2, 32'h58, 32'd9);
        start_run(5'd3);
        bus_write(32'h50, 32'd7);
        vectors++;
        if (ifa.write_count !== 5'd1 || ifa.busy !== 1'b1) begin
            miscompares++; $display("FAIL datamis.first got wc=%0d busy=%b want 1/1", ifa.write_count, ifa.busy);
        end
        bus_write(32'h54, 32'd7);
        bus_write(32'h58, 32'd8);
        vectors++;
        if ({ifa.busy, ifa.done, ifa.pass} !== 3'b010) begin
            miscompares++; $display("FAIL datamis.flags got %b want 010", {ifa.busy, ifa.done, ifa.pass});
        end
        vectors++;
        if (ifa.fail_code !== 3'd2 || ifa.fail_idx !== 4'd2 || ifa.write_count !== 5'd2) begin
            miscompares++; $display("FAIL datamis.fields got fc=%0d idx=%0d wc=%0d want 2/2/2",
                                    ifa.fail_code, ifa.fail_idx, ifa.write_count);
        end
    endtask

    task automatic test_back_to_back();
        start_run(5'd3);
        bus_write(32'h50, 32'd7);
        bus_write(32'h54, 32'd7);
        bus_write(32'h58, 32'd9);
        vectors++;
        if (ifa.pass !== 1'b1 || ifa.write_count !== 5'd3 || ifa.fail_code !== 3'd0) begin
            miscompares++; $display("FAIL b2b.pass got pass=%b wc=%0d fc=%0d want 1/3/0",
                                    ifa.pass, ifa.write_count, ifa.fail_code);
        end
    endtask

    task automatic test_addr_mismatch_clear();
        program_entry(4'd0, 32'd84, 32'hFFFF7F02);
        start_run(5'd1);
        bus_write(32'd80, 32'hFFFF7F02);
        vectors++;
        if (ifa.fail_code !== 3'd1 || ifa.fail_idx !== 4'd0 || ifa.done !== 1'b1) begin
            miscompares++; $display("FAIL addrmis.fields got fc=%0d idx=%0d done=%b want 1/0/1",
                                    ifa.fail_code, ifa.fail_idx, ifa.done);
        end
        step(); step();
        vectors++;
        if (ifa.fail_code !== 3'd1 || ifa.pass !== 1'b0) begin
            miscompares++; $display("FAIL addrmis.sticky got fc=%0d pass=%b want 1/0", ifa.fail_code, ifa.pass);
        end
        start_run(5'd1);
        vectors++;
        if (ifa.fail_code !== 3'd0 || ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
            miscompares++; $display("FAIL addrmis.cleared got fc=%0d busy=%b done=%b want 0/1/0",
                                    ifa.fail_code, ifa.busy, ifa.done);
        end
        bus_write(32'd84, 32'hFFFF7F02);
        vectors++;
        if (ifa.pass !== 1'b1) begin
            miscompares++; $display("FAIL addrmis.rerun_pass got %b want 1", ifa.pass);
        end
        start_run(5'd1);
        bus_write(32'd0, 32'd0);
        vectors++;
        if (ifa.fail_code !== 3'd3) begin
            miscompares++; $display("FAIL both.fail_code got %0d want 3", ifa.fail_code);
        end
    endtask

    task automatic test_timeout();
        start_run(5'd2);
        for (int i = 0; i < 99; i++) begin
            step();
        end
        vectors++;
        if (ifa.done !== 1'b0 || ifa.cycle_count !== 32'd99) begin
            miscompares++; $display("FAIL timeout.early got done=%b cc=%0d want 0/99", ifa.done, ifa.cycle_count);
        end
        step();
        vectors++;
        if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || ifa.fail_code !== 3'd5) begin
            miscompares++; $display("FAIL timeout.verdict got done=%b busy=%b fc=%0d want 1/0/5",
                                    ifa.done, ifa.busy, ifa.fail_code);
        end
        vectors++;
        if (ifa.fail_idx !== 4'd0 || ifa.cycle_count !== 32'd100) begin
            miscompares++; $display("FAIL timeout.fields got idx=%0d cc=%0d want 0/100", ifa.fail_idx, ifa.cycle_count);
        end
    endtask

    task automatic test_strict_extra();
        program_entry(4'd0, 32'h100, 32'hABCD);
        start_run(5'd1);
        bus_write(32'h100, 32'hABCD);
        vectors++;
        if (ifa.pass !== 1'b1 || ifb.pass !== 1'b1) begin
            miscompares++; $display("FAIL extra.prepass got a=%b b=%b want 1/1", ifa.pass, ifb.pass);
        end
        bus_write(32'h100, 32'hABCD);
        vectors++;
        if (ifa.fail_code !== 3'd4 || ifa.fail_idx !== 4'd1 || ifa.pass !== 1'b0 || ifa.done !== 1'b1) begin
            miscompares++; $display("FAIL extra.strict got fc=%0d idx=%0d pass=%b done=%b want 4/1/0/1",
                                    ifa.fail_code, ifa.fail_idx, ifa.pass, ifa.done);
        end
        vectors++;
        if (ifb.pass !== 1'b1 || ifb.fail_code !== 3'd0 || ifb.write_count !== 5'd1) begin
            miscompares++; $display("FAIL extra.lenient got pass=%b fc=%0d wc=%0d want 1/0/1",
                                    ifb.pass, ifb.fail_code, ifb.write_count);
        end
    endtask

    task automatic test_async_reset();
        program_entry(4'd0, 32'h200, 32'h1234);
        start_run(5'd1);
        step(); step();
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({ifa.busy, ifa.done, ifa.pass} !== 3'b000 || ifa.cycle_count !== 32'd0) begin
            miscompares++; $display("FAIL asyncrst.outputs got flags=%b cc=%0d want 000/0",
                                    {ifa.busy, ifa.done, ifa.pass}, ifa.cycle_count);
        end
        #2 reset = 1'b1;
        step();
        vectors++;
        if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            miscompares++; $display("FAIL asyncrst.idle got busy=%b done=%b want 0/0", ifa.busy, ifa.done);
        end
    endtask

    task automatic test_cfg_locked();
        program_entry(4'd0, 32'h300, 32'h55);
        start_run(5'd1);
        program_entry(4'd0, 32'h999, 32'h66);
        bus_write(32'h300, 32'h55);
        vectors++;
        if (ifa.pass !== 1'b1) begin
            miscompares++; $display("FAIL cfglock.same_run got pass=%b fc=%0d want 1/0", ifa.pass, ifa.fail_code);
        end
        start_run(5'd1);
        bus_write(32'h300, 32'h55);
        vectors++;
        if (ifa.pass !== 1'b1) begin
            miscompares++; $display("FAIL cfglock.later_run got pass=%b fc=%0d want 1/0", ifa.pass, ifa.fail_code);
        end
    endtask

    task automatic test_zero_count();
        start_run(5'd0);
        vectors++;
        if ({ifa.busy, ifa.done, ifa.pass} !== 3'b011 || ifa.write_count !== 5'd0) begin
            miscompares++; $display("FAIL zero.pass got flags=%b wc=%0d want 011/0",
                                    {ifa.busy, ifa.done, ifa.pass}, ifa.write_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_data_mismatch();
        test_back_to_back();
        test_addr_mismatch_clear();
        test_timeout();
        test_strict_extra();
        test_async_reset();
        test_cfg_locked();
        test_zero_count();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
